ccu_cmd_parser: RTL
===================

# ccu_cmd_parser

Command-frame parser on the CCU side of the SPI receive path. Consumes the 8-bit AXI-Stream byte stream produced by the SPI receiver, hunts for a sync byte, and parses CMD/LEN/payload/checksum. Validated commands are presented to the CCU core through a valid/ready command port with a random-access payload buffer. Malformed frames are dropped and counted.

## Interface

Parameters:
- PAYLOAD_MAX, 16: maximum payload bytes per frame, range 1..255.
- SYNC_BYTE, 8'hA5: frame start marker.
- AW, $clog2(PAYLOAD_MAX): payload buffer address width, derived, not overridden.

Ports:
- axis_aclk  in  1  sole clock; all logic on rising edge.
- axis_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  8  byte from SPI receiver.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  parser accepts byte.
- s_axis_tlast  in  1  upstream end-of-burst marker.
- cmd_valid  out  1  validated command held for the CCU.
- cmd_ready  in  1  CCU consumes command.
- cmd_op  out  8  CMD byte of held frame.
- cmd_len  out  8  payload length of held frame.
- cmd_rd_addr  in  AW  payload buffer read address.
- cmd_rd_data  out  8  payload byte; registered, 1-cycle latency.
- err_chk  out  1  one-cycle pulse: checksum mismatch.
- err_len  out  1  one-cycle pulse: LEN > PAYLOAD_MAX.
- err_frame  out  1  one-cycle pulse: tlast before CHK byte.
- frame_ok_cnt  out  16  count of accepted frames, wraps.
- frame_err_cnt  out  16  count of dropped frames (any error), wraps.

## Operation

- Byte accepted on any edge with s_axis_tvalid && s_axis_tready.
- States: HUNT, CMD, LEN, PAYLOAD, CHK, HOLD, DISCARD.
- HUNT: accepted byte == SYNC_BYTE -> CMD; anything else ignored silently (no error, no count). tlast in HUNT ignored.
- CMD: store byte to op register, chk_acc <= byte -> LEN.
- LEN: chk_acc ^= byte. LEN > PAYLOAD_MAX -> pulse err_len, increment frame_err_cnt, -> DISCARD. LEN == 0 -> CHK. Else clear byte index -> PAYLOAD.
- PAYLOAD: write byte to buffer[index], chk_acc ^= byte, index++; after LEN-th byte -> CHK.
- CHK: byte == chk_acc -> HOLD, frame_ok_cnt++; else pulse err_chk, frame_err_cnt++ -> HUNT. tlast on CHK byte is legal and ignored.
- tlast on any accepted byte in CMD, LEN, PAYLOAD -> pulse err_frame, frame_err_cnt++, -> HUNT (byte discarded; takes priority over err_len).
- DISCARD: accept and drop bytes until an accepted byte with tlast -> HUNT.
- HOLD: cmd_valid = 1, s_axis_tready = 0; cmd_op/cmd_len stable. cmd_ready -> HUNT.
- Checksum: 8-bit XOR over CMD, LEN and all payload bytes; SYNC excluded.
- Buffer: PAYLOAD_MAX x 8 single-write, single-read; contents valid only for addresses < cmd_len while cmd_valid; addresses >= cmd_len return stale data, no error.
- Counters wrap 16'hFFFF -> 0.

## Timing

- Reset (async assert, sync release): state HUNT; s_axis_tready, cmd_valid, err_* = 0; cmd_op, cmd_len, cmd_rd_data, counters, chk_acc = 0. Buffer contents not reset.
- s_axis_tready = 1 in every state except HOLD and while axis_areset is high; no bubble between frames: byte after CHK is acceptable on the following edge only if the command was already consumed.
- cmd_valid rises the cycle after the CHK byte is accepted; stays high until the edge where cmd_ready = 1; low on the next cycle, s_axis_tready high that same cycle.
- cmd_valid && cmd_ready on the first HOLD cycle is legal: one-cycle command.
- cmd_rd_data reflects buffer[cmd_rd_addr] sampled on the previous edge.
- err_* pulses and counter updates occur on the cycle after the offending byte is accepted; at most one err pulse per frame.
- Reset mid-frame or in HOLD: frame discarded, no error counted.

## Test plan

- Good frame A5 10 03 11 22 33 13 -> cmd_valid with cmd_op=0x10, cmd_len=3; reads addr 0,1,2 give 11,22,33; frame_ok_cnt=1.
- Garbage 00 FF 5A then A5 20 00 20 -> skipped silently; cmd_op=0x20, cmd_len=0; no err pulses.
- A5 10 01 44 00 (expected CHK 0x55) -> err_chk single pulse, no cmd_valid, frame_err_cnt=1; next good frame accepted.
- A5 10 20 ... with PAYLOAD_MAX=16 -> err_len pulse, bytes dropped until tlast, following good frame accepted.
- A5 10 03 11 22(tlast) -> err_frame pulse, state HUNT, no cmd_valid.
- Good frame with cmd_ready low for 10 cycles -> s_axis_tready low throughout, cmd_op stable; ready pulse -> cmd_valid falls, next frame's bytes accepted; async reset mid-payload -> all outputs zero, counters unchanged-from-zero.

Source files
------------

// File: rtl/ccu_cmd_parser.sv
// Command-frame parser on the CCU side of the SPI receive path.
// Hunts for SYNC, parses CMD/LEN/payload/XOR checksum and holds commands.
module ccu_cmd_parser #(
  parameter int         PAYLOAD_MAX = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         AW          = $clog2(PAYLOAD_MAX)
) (
  input  logic          axis_aclk,
  input  logic          axis_areset,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_op,
  output logic [7:0]    cmd_len,
  input  logic [AW-1:0] cmd_rd_addr,
  output logic [7:0]    cmd_rd_data,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_frame,
  output logic [15:0]   frame_ok_cnt,
  output logic [15:0]   frame_err_cnt
);

  localparam logic [2:0] S_HUNT = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [2:0] S_DISC = 3'd6;

  localparam logic [8:0] LEN_MAX = 9'(PAYLOAD_MAX);

  logic [2:0] state;
  logic [7:0] chk_acc;
  logic [7:0] idx;
  logic [7:0] idx_nxt;
  logic [7:0] op_q;
  logic [7:0] len_q;
  logic [7:0] mem [PAYLOAD_MAX];
  logic       take;
  logic       in_body;

  assign s_axis_tready = (state != S_HOLD) && !axis_areset;
  assign take          = s_axis_tvalid && s_axis_tready;
  assign cmd_valid     = (state == S_HOLD);
  assign cmd_op        = op_q;
  assign cmd_len       = len_q;
  assign idx_nxt       = idx + 8'd1;
  assign in_body       = (state == S_CMD) || (state == S_LEN)
                      || (state == S_PAY);

  // Truncated payload bytes are never written.
  always_ff @(posedge axis_aclk) begin
    if (take && state == S_PAY && !s_axis_tlast)
      mem[idx[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state         <= S_HUNT;
      chk_acc       <= 8'd0;
      idx           <= 8'd0;
      op_q          <= 8'd0;
      len_q         <= 8'd0;
      cmd_rd_data   <= 8'd0;
      err_chk       <= 1'b0;
      err_len       <= 1'b0;
      err_frame     <= 1'b0;
      frame_ok_cnt  <= 16'd0;
      frame_err_cnt <= 16'd0;
    end else begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_frame   <= 1'b0;
      cmd_rd_data <= mem[cmd_rd_addr];
      if (state == S_HOLD) begin
        if (cmd_ready)
          state <= S_HUNT;
      end else if (take) begin
        if (in_body && s_axis_tlast) begin
          err_frame     <= 1'b1;
          frame_err_cnt <= frame_err_cnt + 16'd1;
          state         <= S_HUNT;
        end else begin
          case (state)
            S_HUNT: begin
              if (s_axis_tdata == SYNC_BYTE)
                state <= S_CMD;
            end
            S_CMD: begin
              op_q    <= s_axis_tdata;
              chk_acc <= s_axis_tdata;
              state   <= S_LEN;
            end
            S_LEN: begin
              chk_acc <= chk_acc ^ s_axis_tdata;
              len_q   <= s_axis_tdata;
              idx     <= 8'd0;
              if ({1'b0, s_axis_tdata} > LEN_MAX) begin
                err_len       <= 1'b1;
                frame_err_cnt <= frame_err_cnt + 16'd1;
                state         <= S_DISC;
              end else if (s_axis_tdata == 8'd0) begin
                state <= S_CHK;
              end else begin
                state <= S_PAY;
              end
            end
            S_PAY: begin
              chk_acc <= chk_acc ^ s_axis_tdata;
              idx     <= idx_nxt;
              if (idx_nxt == len_q)
                state <= S_CHK;
            end
            S_CHK: begin
              if (s_axis_tdata == chk_acc) begin
                frame_ok_cnt <= frame_ok_cnt + 16'd1;
                state        <= S_HOLD;
              end else begin
                err_chk       <= 1'b1;
                frame_err_cnt <= frame_err_cnt + 16'd1;
                state         <= S_HUNT;
              end
            end
            S_DISC: begin
              if (s_axis_tlast)
                state <= S_HUNT;
            end
            default: state <= S_HUNT;
          endcase
        end
      end
    end
  end

endmodule
